zstr_fifo: RTL and testbench

Buffering stage for the z stream protocol, inserted between a z stream source and drain (for example, between `zstr_src` and `zstr_drn`) to absorb backpressure and decouple their handshakes. It accepts words on a z stream slave port, stores up to QL of them in order, and presents them on a z stream master port. It also reports its current occupancy.

---
 rtl/zstr_pkg.sv | 28 ++
 rtl/zstr_fifo_mem.sv | 31 +++
 rtl/zstr_fifo.sv | 116 +++++++++++
 tb/tb_zstr_fifo.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/zstr_pkg.sv
// zstr_pkg: shared definitions for the z stream blocks (zstr_src, zstr_drn,
// zstr_fifo).
//   - zstr_ptr_w(): pointer width for a queue of a given length, including
//     the wrap flag bit
//   - ZSTR_XZ: per-bit value driven on an idle z stream bus
//   - zstr_xfer_e / zstr_xfer_kind(): classify one port's handshake in a cycle
package zstr_pkg;

    localparam logic ZSTR_XZ = 1'bx;

    typedef enum logic [1:0] {
        ZSTR_IDLE  = 2'd0,  // vld low
        ZSTR_STALL = 2'd1,  // vld high, rdy low: word held
        ZSTR_XFER  = 2'd2   // vld and rdy high: word moves on this edge
    } zstr_xfer_e;

    function automatic int unsigned zstr_ptr_w(input int unsigned ql);
        return $clog2(ql) + 1;
    endfunction

    function automatic zstr_xfer_e zstr_xfer_kind(input logic vld, input logic rdy);
        if (!vld) begin
            return ZSTR_IDLE;
        end
        return rdy ? ZSTR_XFER : ZSTR_STALL;
    endfunction

endpackage

// File: rtl/zstr_fifo_mem.sv
// zstr_fifo_mem: QL x BW storage array for zstr_fifo.
//   clk   - write clock
//   we    - write enable (one word per rising edge)
//   waddr - write index
//   wdata - write data
//   raddr - read index (asynchronous read)
//   rdata - word stored at raddr
// Contents are never reset.
module zstr_fifo_mem #(
    parameter int unsigned BW = 8,
    parameter int unsigned QL = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [$clog2(QL)-1:0] waddr,
    input  logic [BW-1:0]         wdata,
    input  logic [$clog2(QL)-1:0] raddr,
    output logic [BW-1:0]         rdata
);

    logic [BW-1:0] mem_q [QL];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/zstr_fifo.sv
// zstr_fifo: buffering stage for the z stream protocol. Stores up to QL words
// in order between a slave port (zi_*) and a master port (zo_*).
//   clk    - system clock
//   rst    - asynchronous active-high reset
//   zi_vld - input transfer valid
//   zi_bus - input data
//   zi_rdy - input transfer ready (!full, registered-state only)
//   zo_vld - output transfer valid
//   zo_bus - output data, XZ while zo_vld is low
//   zo_rdy - output transfer ready
//   cnt    - number of stored words, 0..QL
// Optional feature: define ZSTR_FIFO_BYPASS_EN for zero-latency fall-through
// when the buffer is empty.
module zstr_fifo
    import zstr_pkg::*;
#(
    parameter int unsigned    BW = 8,
    parameter logic [BW-1:0] XZ = {BW{ZSTR_XZ}},
    parameter int unsigned    QL = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      zi_vld,
    input  logic [BW-1:0]             zi_bus,
    output logic                      zi_rdy,
    output logic                      zo_vld,
    output logic [BW-1:0]             zo_bus,
    input  logic                      zo_rdy,
    output logic [zstr_ptr_w(QL)-1:0] cnt
);

    localparam int unsigned PW = zstr_ptr_w(QL);
    localparam int unsigned AW = PW - 1;

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic [BW-1:0] rd_data;
    zstr_xfer_e    zi_kind;
    zstr_xfer_e    zo_kind;

    // Wrap flag in the MSB distinguishes full from empty when indices match.
    assign empty  = (wptr_q == rptr_q);
    assign full   = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    assign cnt    = wptr_q - rptr_q;
    assign zi_rdy = !full;

    assign zi_kind = zstr_xfer_kind(zi_vld, zi_rdy);
    assign zo_kind = zstr_xfer_kind(zo_vld, zo_rdy);

`ifdef ZSTR_FIFO_BYPASS_EN
    logic pass;

    // An empty buffer forwards the incoming word directly; it is stored only
    // if the drain is not taking it in the same cycle.
    assign pass = empty && (zi_kind == ZSTR_XFER) && (zo_kind == ZSTR_XFER);

    always_comb begin
        zo_vld = !empty || zi_vld;
        zo_bus = XZ;
        if (!empty) begin
            zo_bus = rd_data;
        end else if (zi_vld) begin
            zo_bus = zi_bus;
        end
    end

    assign push = (zi_kind == ZSTR_XFER) && !pass;
    assign pop  = (zo_kind == ZSTR_XFER) && !empty;
`else
    always_comb begin
        zo_vld = !empty;
        zo_bus = empty ? XZ : rd_data;
    end

    assign push = (zi_kind == ZSTR_XFER);
    assign pop  = (zo_kind == ZSTR_XFER);
`endif

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    zstr_fifo_mem #(
        .BW (BW),
        .QL (QL)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wptr_q[AW-1:0]),
        .wdata (zi_bus),
        .raddr (rptr_q[AW-1:0]),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_zstr_fifo.sv
module tb_zstr_fifo;

    localparam int unsigned   QL   = 4;
    localparam logic [7:0]    IDLE = 8'hE7;
`ifdef ZSTR_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       zi_vld;
    logic [7:0] zi_bus;
    logic       zi_rdy;
    logic       zo_vld;
    logic [7:0] zo_bus;
    logic       zo_rdy;
    logic [2:0] cnt;

    int total = 0;
    int bad   = 0;

    // Reference model: the stored words in arrival order.
    logic [7:0] mq[$];

    zstr_fifo #(
        .BW (8),
        .XZ (IDLE),
        .QL (QL)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .zi_vld (zi_vld),
        .zi_bus (zi_bus),
        .zi_rdy (zi_rdy),
        .zo_vld (zo_vld),
        .zo_bus (zo_bus),
        .zo_rdy (zo_rdy),
        .cnt    (cnt)
    );

    always #5 clk = ~clk;

    function automatic logic m_vld();
        return (mq.size() > 0) || (BYP && zi_vld);
    endfunction

    function automatic logic [7:0] m_bus();
        if (mq.size() > 0) return mq[0];
        if (BYP && zi_vld) return zi_bus;
        return IDLE;
    endfunction

    task automatic drive(input logic v, input logic [7:0] d, input logic r);
        @(negedge clk);
        zi_vld = v;
        zi_bus = d;
        zo_rdy = r;
        #1;
    endtask

    // Apply the handshake rules to the model, then take the clock edge.
    task automatic advance();
        int  n;
        bit  pass;
        n    = mq.size();
        pass = BYP && (n == 0) && zi_vld && zo_rdy;
        if (!pass) begin
            if (zo_rdy && n > 0) void'(mq.pop_front());
            if (zi_vld && n < QL) mq.push_back(zi_bus);
        end
        @(posedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; zi_vld = 1'b0; zi_bus = '0; zo_rdy = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++; if (zi_rdy !== 1'b1) begin bad++; $display("FAIL reset_zi_rdy got=%b exp=1", zi_rdy); end
        total++; if (zo_vld !== 1'b0) begin bad++; $display("FAIL reset_zo_vld got=%b exp=0", zo_vld); end
        total++; if (zo_bus !== IDLE) begin bad++; $display("FAIL reset_zo_bus got=%h exp=%h", zo_bus, IDLE); end
        total++; if (cnt !== 3'd0)    begin bad++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
        rst = 1'b0;
        mq.delete();
        drive(0, 8'h00, 0);
        total++; if (cnt !== 3'd0) begin bad++; $display("FAIL post_reset_cnt got=%0d exp=0", cnt); end
    endtask

    task automatic test_fill_drain();
        logic [7:0] words [4];
        words = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            drive(1, words[i], 0);
            total++; if (zi_rdy !== 1'b1) begin bad++; $display("FAIL fill_zi_rdy[%0d] got=%b exp=1", i, zi_rdy); end
            total++; if (cnt !== 3'(i)) begin bad++; $display("FAIL fill_cnt[%0d] got=%0d exp=%0d", i, cnt, i); end
            advance();
        end
        drive(0, 8'h00, 0);
        total++; if (zi_rdy !== 1'b0) begin bad++; $display("FAIL full_zi_rdy got=%b exp=0", zi_rdy); end
        total++; if (cnt !== 3'd4)    begin bad++; $display("FAIL full_cnt got=%0d exp=4", cnt); end
        for (int i = 0; i < 4; i++) begin
            drive(0, 8'h00, 1);
            total++; if (zo_vld !== 1'b1) begin bad++; $display("FAIL drain_vld[%0d] got=%b exp=1", i, zo_vld); end
            total++; if (zo_bus !== words[i]) begin bad++; $display("FAIL drain_bus[%0d] got=%h exp=%h", i, zo_bus, words[i]); end
            advance();
        end
        drive(0, 8'h00, 0);
        total++; if (cnt !== 3'd0)    begin bad++; $display("FAIL drained_cnt got=%0d exp=0", cnt); end
        total++; if (zo_vld !== 1'b0) begin bad++; $display("FAIL drained_vld got=%b exp=0", zo_vld); end
        total++; if (zo_bus !== IDLE) begin bad++; $display("FAIL drained_bus got=%h exp=%h", zo_bus, IDLE); end
    endtask

    task automatic test_stream();
        int         recv = 0;
        logic       exp_v;
        logic [7:0] exp_w;
        for (int k = 0; k < 18; k++) begin
            drive(k < 16, 8'(8'h30 + k), 1);
            exp_v = BYP ? (k < 16) : (k >= 1 && k <= 16);
            total++; if (zo_vld !== exp_v) begin bad++; $display("FAIL stream_vld[%0d] got=%b exp=%b", k, zo_vld, exp_v); end
            if (exp_v) begin
                exp_w = 8'(8'h30 + recv);
                total++; if (zo_bus !== exp_w) begin bad++; $display("FAIL stream_bus[%0d] got=%h exp=%h", k, zo_bus, exp_w); end
                recv++;
            end
            total++; if (cnt > 3'd1) begin bad++; $display("FAIL stream_cnt[%0d] got=%0d exp<=1", k, cnt); end
            advance();
        end
        total++; if (recv != 16) begin bad++; $display("FAIL stream_count got=%0d exp=16", recv); end
    endtask

    task automatic test_full_pop();
        logic [7:0] rest [4];
        rest = '{8'h22, 8'h33, 8'h44, 8'h55};
        drive(1, 8'h11, 0); advance();
        drive(1, 8'h22, 0); advance();
        drive(1, 8'h33, 0); advance();
        drive(1, 8'h44, 0); advance();
        drive(1, 8'h55, 1);
        total++; if (zi_rdy !== 1'b0) begin bad++; $display("FAIL fullpop_zi_rdy got=%b exp=0", zi_rdy); end
        total++; if (zo_bus !== 8'h11) begin bad++; $display("FAIL fullpop_bus got=%h exp=11", zo_bus); end
        advance();
        drive(1, 8'h55, 0);
        total++; if (zi_rdy !== 1'b1) begin bad++; $display("FAIL fullpop_reopen got=%b exp=1", zi_rdy); end
        total++; if (cnt !== 3'd3)    begin bad++; $display("FAIL fullpop_cnt3 got=%0d exp=3", cnt); end
        advance();
        drive(0, 8'h00, 0);
        total++; if (cnt !== 3'd4) begin bad++; $display("FAIL fullpop_cnt4 got=%0d exp=4", cnt); end
        for (int i = 0; i < 4; i++) begin
            drive(0, 8'h00, 1);
            total++; if (zo_bus !== rest[i]) begin bad++; $display("FAIL fullpop_drain[%0d] got=%h exp=%h", i, zo_bus, rest[i]); end
            advance();
        end
    endtask

    task automatic test_random();
        logic       hold = 1'b0;
        logic [7:0] held = '0;
        for (int k = 0; k < 1000; k++) begin
            drive($urandom_range(0, 9) < 6, 8'($urandom_range(0, 255)), $urandom_range(0, 1) == 1);
            total++; if (zo_vld !== m_vld()) begin bad++; $display("FAIL rand_vld[%0d] got=%b exp=%b", k, zo_vld, m_vld()); end
            if (m_vld()) begin
                total++; if (zo_bus !== m_bus()) begin bad++; $display("FAIL rand_bus[%0d] got=%h exp=%h", k, zo_bus, m_bus()); end
            end
            total++; if (zi_rdy !== (mq.size() < QL)) begin bad++; $display("FAIL rand_zi_rdy[%0d] got=%b exp=%b", k, zi_rdy, mq.size() < QL); end
            total++; if (cnt !== 3'(mq.size())) begin bad++; $display("FAIL rand_cnt[%0d] got=%0d exp=%0d", k, cnt, mq.size()); end
            if (hold) begin
                total++; if (zo_vld !== 1'b1 || zo_bus !== held) begin bad++; $display("FAIL rand_stable[%0d] got=%b/%h exp=1/%h", k, zo_vld, zo_bus, held); end
            end
            hold = zo_vld && !zo_rdy;
            held = zo_bus;
            advance();
        end
        for (int k = 0; k <= QL; k++) begin
            drive(0, 8'h00, 1);
            if (m_vld()) begin
                total++; if (zo_bus !== m_bus()) begin bad++; $display("FAIL rand_flush[%0d] got=%h exp=%h", k, zo_bus, m_bus()); end
            end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        drive(1, 8'hC1, 0); advance();
        drive(1, 8'hC2, 0); advance();
        drive(1, 8'hC3, 0); advance();
        drive(0, 8'h00, 0);
        total++; if (cnt !== 3'd3) begin bad++; $display("FAIL mid_pre_cnt got=%0d exp=3", cnt); end
        #1 rst = 1'b1;
        #1;
        mq.delete();
        total++; if (cnt !== 3'd0)    begin bad++; $display("FAIL mid_cnt got=%0d exp=0", cnt); end
        total++; if (zo_vld !== 1'b0) begin bad++; $display("FAIL mid_vld got=%b exp=0", zo_vld); end
        total++; if (zi_rdy !== 1'b1) begin bad++; $display("FAIL mid_zi_rdy got=%b exp=1", zi_rdy); end
        total++; if (zo_bus !== IDLE) begin bad++; $display("FAIL mid_bus got=%h exp=%h", zo_bus, IDLE); end
        @(negedge clk);
        rst = 1'b0;
        drive(1, 8'hA5, 0); advance();
        drive(0, 8'h00, 1);
        total++; if (zo_vld !== 1'b1 || zo_bus !== 8'hA5) begin bad++; $display("FAIL mid_next got=%b/%h exp=1/a5", zo_vld, zo_bus); end
        advance();
        drive(0, 8'h00, 0);
        total++; if (cnt !== 3'd0) begin bad++; $display("FAIL mid_end_cnt got=%0d exp=0", cnt); end
    endtask

    task automatic test_bypass();
        drive(1, 8'h7E, 1);
        if (BYP) begin
            total++; if (zo_vld !== 1'b1 || zo_bus !== 8'h7E) begin bad++; $display("FAIL byp_same got=%b/%h exp=1/7e", zo_vld, zo_bus); end
            advance();
            drive(0, 8'h00, 1);
            total++; if (cnt !== 3'd0 || zo_vld !== 1'b0) begin bad++; $display("FAIL byp_after got=%0d/%b exp=0/0", cnt, zo_vld); end
        end else begin
            total++; if (zo_vld !== 1'b0) begin bad++; $display("FAIL nobyp_same got=%b exp=0", zo_vld); end
            advance();
            drive(0, 8'h00, 1);
            total++; if (zo_vld !== 1'b1 || zo_bus !== 8'h7E) begin bad++; $display("FAIL nobyp_next got=%b/%h exp=1/7e", zo_vld, zo_bus); end
            total++; if (cnt !== 3'd1) begin bad++; $display("FAIL nobyp_cnt got=%0d exp=1", cnt); end
        end
        advance();
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_stream();
        test_full_pop();
        test_random();
        test_reset_mid();
        test_bypass();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
